// File: rtl/frame_capture_ctrl_if.sv
// rtl/frame_capture_ctrl_if.sv - sample stream bus with frame markers (tuser = first beat, tlast = last beat)
interface frame_capture_ctrl_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - trigger and frame sequencing controller for the ADC sample path
// Forwards whole FRAME_LEN-sample frames after a level-crossing or external trigger.
module frame_capture_ctrl #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_ce,
  input  logic                 i_arm,
  input  logic                 i_abort,
  input  logic                 i_trig_en,
  input  logic                 i_trig_edge,
  input  logic signed [DW-1:0] i_trig_level,
  input  logic                 i_ext_trig,
  input  logic [7:0]           i_frame_count,
  input  logic [CNT_W-1:0]     i_holdoff,
  frame_capture_ctrl_if.slave  s_axis,
  frame_capture_ctrl_if.master m_axis,
  output logic [1:0]           o_state,
  output logic [7:0]           o_frames_done,
  output logic                 o_done,
  output logic                 o_aborted
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF   = 2'd3;

  localparam int               IDX_W    = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [CNT_W-1:0]     r_hold;
  logic signed [DW-1:0] r_prev;
  logic                 r_prev_valid;
  logic [7:0]           r_frames_done;
  logic                 r_done;
  logic                 r_aborted;

  logic [DW-1:0]        r_tdata;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic                 r_tuser;

  logic                 w_tready;
  logic                 w_accept;
  logic signed [DW-1:0] w_cur;
  logic                 w_level_hit;
  logic                 w_trig;
  logic                 w_last;
  logic [7:0]           w_fd_inc;
  logic                 w_burst_end;
  logic                 w_load;
  logic                 w_load_user;
  logic                 w_load_last;

  // IDLE and HOLDOFF discard beats, so they never need the output register.
  assign w_tready = i_ce && ((r_state == ST_IDLE) || (r_state == ST_HOLDOFF) ||
                             !r_tvalid || m_axis.tready);
  assign w_accept = s_axis.tvalid && w_tready;
  assign w_cur    = $signed(s_axis.tdata);

  assign w_level_hit = r_prev_valid &&
                       (i_trig_edge ? ((r_prev > i_trig_level) && (i_trig_level >= w_cur))
                                    : ((r_prev < i_trig_level) && (i_trig_level <= w_cur)));
  assign w_trig      = !i_trig_en || i_ext_trig || w_level_hit;

  assign w_last      = (r_idx == LAST_IDX);
  assign w_fd_inc    = r_frames_done + 8'd1;
  assign w_burst_end = (i_frame_count != 8'd0) && (w_fd_inc == i_frame_count);

  // An abort in the same cycle as an accepted beat drops that beat.
  assign w_load      = w_accept && !i_abort &&
                       (((r_state == ST_WAIT_TRIG) && w_trig) || (r_state == ST_CAPTURE));
  assign w_load_user = (r_state == ST_WAIT_TRIG);
  assign w_load_last = (r_state == ST_CAPTURE) && w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_hold        <= '0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_frames_done <= 8'd0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (i_abort) begin
        r_state   <= ST_IDLE;
        r_idx     <= '0;
        r_aborted <= (r_state != ST_IDLE);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_arm) begin
              r_state       <= ST_WAIT_TRIG;
              r_frames_done <= 8'd0;
              r_prev_valid  <= 1'b0;
            end
          end
          ST_WAIT_TRIG: begin
            if (w_accept) begin
              if (w_trig) begin
                r_idx   <= IDX_W'(1);
                r_state <= ST_CAPTURE;
              end else begin
                r_prev       <= w_cur;
                r_prev_valid <= 1'b1;
              end
            end
          end
          ST_CAPTURE: begin
            if (w_accept) begin
              if (w_last) begin
                r_idx         <= '0;
                r_frames_done <= w_fd_inc;
                if (w_burst_end) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                end else if (i_holdoff == '0) begin
                  r_state      <= ST_WAIT_TRIG;
                  r_prev_valid <= 1'b0;
                end else begin
                  r_state <= ST_HOLDOFF;
                  r_hold  <= i_holdoff;
                end
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
          ST_HOLDOFF: begin
            if (w_accept) begin
              r_hold <= r_hold - CNT_W'(1);
              if (r_hold == CNT_W'(1)) begin
                r_state      <= ST_WAIT_TRIG;
                r_prev_valid <= 1'b0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Single output register stage; a stalled beat is held untouched until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= s_axis.tdata;
      r_tvalid <= 1'b1;
      r_tlast  <= w_load_last;
      r_tuser  <= w_load_user;
    end else if (m_axis.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign s_axis.tready = w_tready;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = r_tuser;

  assign o_state       = r_state;
  assign o_frames_done = r_frames_done;
  assign o_done        = r_done;
  assign o_aborted     = r_aborted;

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Trigger and frame-sequencing controller on the ADC sample path, ahead of the frame/FFT chain. It watches the continuous AXI-Stream sample flow, waits for a level-crossing or external trigger, and forwards exactly FRAME_LEN-sample frames marked with tuser/tlast. It supports single-shot or N-frame bursts, continuous capture, a holdoff between frames and an abort. Software arms it through register-mapped control bits; downstream DSP sees only whole, trigger-aligned frames.

## Interface
- DW, 16, sample width; samples are signed two's complement
- FRAME_LEN, 1024, samples per frame; range 2..65535
- CNT_W, 16, width of the holdoff counter
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable for input acceptance and state advance
- arm  in  1  start-capture pulse; honoured only in IDLE
- abort  in  1  return-to-IDLE pulse; honoured in any state
- trig_en  in  1  0 = trigger on the first accepted beat; 1 = use a level or external trigger
- trig_edge  in  1  0 = rising crossing, 1 = falling crossing
- trig_level  in  DW  signed trigger threshold
- ext_trig  in  1  external trigger level, sampled on accepted beats
- frame_count  in  8  frames per arm; 0 = continuous until abort
- holdoff  in  CNT_W  number of input beats discarded after each frame
- tdata_s / tvalid_s / tready_s  in/in/out  DW/1/1  input sample stream
- tdata_m / tvalid_m / tlast_m / tuser_m / tready_m  out/out/out/out/in  DW/1/1/1/1  framed output stream
- state  out  2  0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 HOLDOFF
- frames_done  out  8  frames completed since the last arm; wraps from 255 to 0
- done  out  1  one-cycle pulse when the burst completes
- aborted  out  1  one-cycle pulse when an abort hits a non-IDLE state

## Operation
- Input beat accepted = tvalid_s && tready_s. tready_s is combinational: ce && (state is IDLE or HOLDOFF, or !tvalid_m, or tready_m).
- The output is a single register stage. A pending beat (tvalid_m && !tready_m) is held unchanged.
- IDLE: input is drained and discarded. arm moves to WAIT_TRIG, clears frames_done and clears prev_valid.
- WAIT_TRIG: each accepted beat is tested for a trigger. If no trigger, the beat is discarded, stored as prev and prev_valid is set.
  - Trigger if trig_en=0, or ext_trig=1, or prev_valid && rising && prev < trig_level <= cur, or prev_valid && falling && prev > trig_level >= cur. Comparisons are signed.
  - The trigger beat is loaded into the output with tuser_m=1 as sample 0. Index goes to 1, state goes to CAPTURE.
- CAPTURE: each accepted beat is loaded into the output and the index increments. The beat with index FRAME_LEN-1 carries tlast_m=1, and frames_done increments.
  - After the last beat, if frame_count != 0 and the new frames_done == frame_count: go to IDLE and pulse done.
  - Otherwise, if holdoff==0: go to WAIT_TRIG with prev_valid cleared.
  - Otherwise: go to HOLDOFF and load the counter with holdoff.
- HOLDOFF: accepted beats are discarded and the counter decrements. At the beat that takes it to 0, go to WAIT_TRIG with prev_valid cleared.
- abort: the next state is IDLE from any state. aborted pulses if the state was not IDLE.
  - An already-loaded output beat completes its handshake unmodified; a truncated frame carries no tlast.
  - frames_done is held until the next arm.
- Simultaneous arm and abort: abort wins, and arm is ignored.
- arm outside IDLE is ignored. arm and abort act even when ce=0.
- ce=0: no beats are accepted and state, counters and prev are frozen. The output handshake still completes, and tvalid_m clears on tready_m.
- trig_level, trig_edge, frame_count and holdoff are sampled live. They are meant to be held stable while not in IDLE.

## Timing
- Reset values: state IDLE; tdata_m 0; tvalid_m, tlast_m, tuser_m 0; frames_done 0; done and aborted 0; prev_valid 0. During reset, tready_s = ce.
- Latency: an accepted input beat appears on the output the next cycle.
- Throughput: 1 beat/cycle with tready_m held high.
- done and aborted are asserted in the cycle after the causing event, for exactly 1 cycle.
- A state change takes effect on the clock edge of the deciding beat. The next beat is evaluated in the new state.
- FRAME_LEN-1 index wrap: the index returns to 0 on leaving CAPTURE. No frame ever exceeds FRAME_LEN beats.
- Holdoff with holdoff=1 discards exactly 1 beat.

## Test plan
- Free-run, single frame: trig_en=0, frame_count=1, ramp 0,1,2…, tready_m=1, FRAME_LEN=8, pulse arm. Output must be exactly 8 beats with the values of the first post-arm beat onward, tuser on beat 0, tlast on beat 7. done pulses once, then state=0 and frames_done=1.
- Rising level trigger: trig_level=100, trig_edge=0, input sequence 90,95,99,100,101…. Frame must start at the 100 beat. A first post-arm sample ≥100 must not trigger.
- Falling edge and ext_trig: trig_edge=1, level 0, sine input. The frame must start at the first beat ≤0 after a beat >0. Separately, ext_trig=1 on the 5th post-arm beat must start the frame on that beat.
- Burst with holdoff: frame_count=3, holdoff=4, trig_en=0, FRAME_LEN=8, ramp input. Frames must start at ramp values 0, 12 and 24. frames_done must step 1, 2, 3, and done pulses after the third tlast.
- Backpressure: tready_m toggles randomly. Data must have no loss or duplication, tdata_m must stay stable while stalled, and tlast/tuser positions must be unchanged. With ce=0 for 10 cycles mid-frame, no beats are accepted.
- Abort and reset: abort at sample 3 of a frame must give state=0 the next cycle, an aborted pulse, no further beats and no tlast. Simultaneous arm+abort in IDLE must stay in IDLE. Asserting reset_n low mid-CAPTURE must clear all outputs immediately.
